pi_bcd_converter: RTL
=====================

// Module: pi_bcd_converter
// PURPOSE
//  Sequential double-dabble binary-to-BCD converter between the in_circle/in_square hit counters and the digit renderer.
//  Replaces the per-digit combinational /10**i and %10 logic with one shift-add-3 engine. Takes BIN_W cycles per conversion.
//  Converts once per frame, with start pulsed at vblank. bcd_out stays stable while pixels are drawn.
// PARAMETERS
//  BIN_W     32  width of binary input (counter width)
//  N_DIGITS  10  number of BCD digits produced (4 bits each)
// PORTS
//  Reset: one clock; reset is asynchronous and active-high.
//  clk       in   1            system/pixel clock
//  rst       in   1            async active-high reset
//  start     in   1            request conversion; sampled only in IDLE
//  bin_in    in   BIN_W        binary value; captured on accepted start
//  busy      out  1            high while in SHIFT
//  done      out  1            1-cycle pulse when bcd_out updates
//  overflow  out  1            bin_in >= 10**N_DIGITS (sticky until next done)
//  bcd_out   out  4*N_DIGITS   packed BCD; digit i = bcd_out[4i+3:4i], i=0 is units
// BEHAVIOUR
//  - Reset (async): state=IDLE, busy=0, done=0, overflow=0, bcd_out=0, scratch regs=0.
//  - FSM states: IDLE, SHIFT. There is no separate DONE state.
//    IDLE -> SHIFT when start=1. On that edge:
//      - shift_reg<=bin_in
//      - acc<=0
//      - cnt<=0
//      - ovf_acc<=0
//    SHIFT: each cycle, for every digit nibble d of acc, compute d'=(d>=5)?d+3:d. Then shift left by 1:
//      acc<={acc'[4N-2:0], shift_reg[BIN_W-1]}
//      shift_reg<<=1
//      ovf_acc|=acc'[4N-1]
//      cnt<=cnt+1
//    SHIFT -> IDLE when cnt==BIN_W-1, i.e. on the last shift. On that same edge:
//      - bcd_out<=final acc
//      - overflow<=final ovf_acc
//      - done<=1 for one cycle
//  - Latency: start sampled at edge t gives done high in the cycle after edge t+BIN_W, which is 33 cycles for the defaults.
//  - busy=1 exactly while state==SHIFT. done and busy are never both 1.
//  - start is ignored while busy; there is no queueing. A start in the cycle done=1 (state IDLE) is accepted.
//  - bin_in is ignored except at the accepting edge. Later changes do not corrupt the conversion.
//  - bcd_out and overflow change only on the done edge or on reset. They hold between conversions.
//  - Overflow: set if any 1 is shifted out past digit N_DIGITS-1. bcd_out then holds bin_in mod 10**N_DIGITS.
//    With the defaults this is unreachable (2^32-1 has 10 digits), but it must still be implemented.
//  - Reset mid-SHIFT: abort immediately. Outputs return to reset values and no done pulse is issued.
//  - cnt width = clog2(BIN_W). acc width = 4*N_DIGITS. Each add-3 is 4-bit with no carry into the next nibble.
// STRUCTURE
//  - Package pi_calc_pkg holds:
//    - DIGIT_W=4
//    - N_DIGITS, BIN_W defaults
//    - state encoding localparams IDLE/SHIFT
//    These are shared with the digit renderer.
//  - Sub-module dd_digit_adj: combinational 4-bit nibble, out = (in>=5)?in+3:in. Instantiated N_DIGITS times in a generate loop.
//  - Top-level wiring: start = vblank rising edge, bin_in = in_circle. The renderer reads bcd_out nibbles as the ROM index.
// TESTING
//  1. Reset, then start with bin_in=0 -> done at cycle 33, bcd_out=40'h0, overflow=0, busy high for exactly 32 cycles.
//  2. bin_in=1234567890 -> bcd_out=40'h1234567890 at done. Change bin_in during busy -> result unchanged.
//  3. bin_in=32'hFFFFFFFF -> bcd_out=40'h4294967295, overflow=0. Also check bin_in=9,10,99,100 -> 0x9,0x10,0x99,0x100.
//  4. Pulse start every cycle for 100 cycles with bin_in=42.
//     -> done every 33 cycles, including the back-to-back start in the done cycle, and bcd_out=40'h42.
//  5. Assert rst at cycle 10 of SHIFT -> busy=0, bcd_out=0, and no done pulse.
//     A fresh start with bin_in=7 -> bcd_out=0x7.
//  6. Instance with BIN_W=36, N_DIGITS=10, bin_in=10000000005 -> overflow=1, bcd_out=40'h0000000005.
//     The next conversion with bin_in=5 clears overflow.

Source files
------------

// File: rtl/pi_calc_pkg.sv
// Shared constants for the pi display path: digit width, default sizes and
// the converter FSM encoding (also used by the digit renderer).
package pi_calc_pkg;
    localparam int DIGIT_W      = 4;
    localparam int DEF_N_DIGITS = 10;
    localparam int DEF_BIN_W    = 32;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
endpackage

// File: rtl/dd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more so the
// following left shift carries into the next decade.
module dd_digit_adj (
    input  logic [3:0] in,
    output logic [3:0] out
);
    assign out = (in >= 4'd5) ? in + 4'd3 : in;
endmodule

// File: rtl/pi_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle,
// BIN_W cycles per conversion, result held in bcd_out between conversions.
module pi_bcd_converter
    import pi_calc_pkg::*;
#(
    parameter int BIN_W    = DEF_BIN_W,
    parameter int N_DIGITS = DEF_N_DIGITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin_in,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [DIGIT_W*N_DIGITS-1:0] bcd_out
);
    localparam int ACC_W = DIGIT_W * N_DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    logic [0:0]       state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0] bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_shift;
    logic             ovf_shift;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
        dd_digit_adj u_adj (
            .in  (acc_q[i*DIGIT_W +: DIGIT_W]),
            .out (acc_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    // A one shifted out of the top digit is a carry worth 10**N_DIGITS.
    assign acc_shift = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
    assign ovf_shift = ovf_acc_q | acc_adj[ACC_W-1];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    shift_d   = bin_in;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            SHIFT: begin
                acc_d     = acc_shift;
                shift_d   = shift_q << 1;
                ovf_acc_d = ovf_shift;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d    = IDLE;
                    bcd_d      = acc_shift;
                    overflow_d = ovf_shift;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;
endmodule
